// File: rtl/tow_referee.sv
// Tug-of-war referee: debounces two player buttons on the slow tick,
// moves the rope position, detects a win and blinks the winner LED.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   slowenable  one-cycle sampling tick from the slow-enable divider
//   btn_left    raw left-player button (async, active-high)
//   btn_right   raw right-player button (async, active-high)
//   leds        rope display, bit 0 = leftmost
//   win_left    high while the left player has won
//   win_right   high while the right player has won

module tow_referee #(
    parameter int NLED        = 9,
    parameter int FLASH_TICKS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            slowenable,
    input  logic            btn_left,
    input  logic            btn_right,
    output logic [NLED-1:0] leds,
    output logic            win_left,
    output logic            win_right
);

    localparam int PW = $clog2(NLED);
    localparam int CW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

    localparam logic [PW-1:0]   CENTER  = PW'((NLED - 1) / 2);
    localparam logic [PW-1:0]   LAST    = PW'(NLED - 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(FLASH_TICKS - 1);
    localparam logic [NLED-1:0] LED_RST =
        {{(NLED - 1){1'b0}}, 1'b1} << CENTER;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        WIN_L,
        WIN_R
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pos, pos_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            phase, phase_n;
    logic [1:0]      sync_l, sync_r;
    logic            samp_l, samp_l_n;
    logic            samp_r, samp_r_n;
    logic            prev_l, prev_l_n;
    logic            prev_r, prev_r_n;
    logic            ev_l, ev_r;
    logic [NLED-1:0] leds_n;
    logic            win_left_n, win_right_n;

    // Synchronizers run every clock, independent of the tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_l <= '0;
            sync_r <= '0;
        end else begin
            sync_l <= {sync_l[0], btn_left};
            sync_r <= {sync_r[0], btn_right};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            pos       <= CENTER;
            cnt       <= '0;
            phase     <= 1'b1;
            samp_l    <= 1'b0;
            samp_r    <= 1'b0;
            prev_l    <= 1'b0;
            prev_r    <= 1'b0;
            leds      <= LED_RST;
            win_left  <= 1'b0;
            win_right <= 1'b0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            cnt       <= cnt_n;
            phase     <= phase_n;
            samp_l    <= samp_l_n;
            samp_r    <= samp_r_n;
            prev_l    <= prev_l_n;
            prev_r    <= prev_r_n;
            leds      <= leds_n;
            win_left  <= win_left_n;
            win_right <= win_right_n;
        end
    end

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        cnt_n    = cnt;
        phase_n  = phase;
        samp_l_n = samp_l;
        samp_r_n = samp_r;
        prev_l_n = prev_l;
        prev_r_n = prev_r;
        ev_l     = 1'b0;
        ev_r     = 1'b0;

        if (slowenable) begin
            samp_l_n = sync_l[1];
            samp_r_n = sync_r[1];
            prev_l_n = samp_l;
            prev_r_n = samp_r;
            // Edge seen on the values being loaded this tick.
            ev_l     = sync_l[1] & ~samp_l;
            ev_r     = sync_r[1] & ~samp_r;

            unique case (state)
                IDLE: begin
                    // Buttons held through reset must be released first.
                    if (!sync_l[1] && !sync_r[1]) begin
                        state_n = PLAY;
                    end
                end
                PLAY: begin
                    if (ev_l && !ev_r) begin
                        pos_n = pos - PW'(1);
                    end else if (ev_r && !ev_l) begin
                        pos_n = pos + PW'(1);
                    end
                    if (pos_n == '0) begin
                        state_n = WIN_L;
                        cnt_n   = '0;
                        phase_n = 1'b1;
                    end else if (pos_n == LAST) begin
                        state_n = WIN_R;
                        cnt_n   = '0;
                        phase_n = 1'b1;
                    end
                end
                WIN_L, WIN_R: begin
                    if (cnt == CNT_MAX) begin
                        cnt_n   = '0;
                        phase_n = ~phase;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state values so the
    // display changes on the edge of the deciding tick.
    always_comb begin
        leds_n      = '0;
        win_left_n  = 1'b0;
        win_right_n = 1'b0;
        unique case (state_n)
            WIN_L: begin
                win_left_n = 1'b1;
                leds_n[0]  = phase_n;
            end
            WIN_R: begin
                win_right_n      = 1'b1;
                leds_n[NLED-1]   = phase_n;
            end
            default: leds_n[pos_n] = 1'b1;
        endcase
    end

endmodule

// File: doc/tow_referee.md
Name: tow_referee

Overview:
- Game-logic stage of the tug-of-war design, directly downstream of the 1-in-256 slow-enable divider.
- Consumes the divider's single-cycle `slowenable` strobe as its sampling tick, which debounces the two player buttons.
- Converts debounced presses into rope-position moves, detects a win and drives the LED rope, including a winner blink.
- Runs entirely on the single system clock; `slowenable` is a clock enable only.

Parameters:
- NLED, 9: number of rope LEDs; must be odd and >= 3; CENTER = (NLED-1)/2.
- FLASH_TICKS, 64: `slowenable` ticks per half-period of the winner blink; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (reset when rst==0 at a rising clk edge).
- slowenable  in  1  one-cycle tick from the divider; all game decisions are taken only on cycles where it is 1.
- btn_left  in  1  raw left-player button, active-high, asynchronous to clk.
- btn_right  in  1  raw right-player button, active-high, asynchronous to clk.
- leds  out  NLED  rope display; bit 0 = leftmost.
- win_left  out  1  high while the left player has won.
- win_right  out  1  high while the right player has won.

Behaviour:
- Reset (rst==0 at edge):
  - state=IDLE, pos=CENTER, flash counter=0, blink phase=1, all synchronizer and sample flops=0.
  - leds = one-hot at CENTER; win_left=win_right=0.
  - Reset takes priority over everything and aborts any game or blink in progress.
- Synchronizer: each button passes through a 2-flop synchronizer clocked every clk, independent of `slowenable`.
- Debounce sampling:
  - On each tick (`slowenable`==1), the synchronized level is copied into `samp_*`, and the old `samp_*` into `prev_*`.
  - Press event = samp==1 && prev==0, evaluated using the values being loaded on that tick.
  - A press is therefore registered at most once per hold. Any glitch that starts and ends between two ticks is ignored.
- State machine (transitions only on ticks):
  - IDLE: when both sampled levels are 0, go to PLAY. Presses held across reset never score.
  - PLAY, left event only: pos <= pos-1.
  - PLAY, right event only: pos <= pos+1.
  - PLAY, both events on the same tick: no move (tie).
  - PLAY, neither event: hold.
  - PLAY, new pos==0: go to WIN_L on the same tick. New pos==NLED-1: go to WIN_R on the same tick.
  - WIN_L / WIN_R: ignore buttons; pos frozen; exit only via reset.
- Arithmetic: pos is clog2(NLED) bits. It can never pass 0 or NLED-1, because the win state is entered at the boundary and moves stop there.
- Outputs (registered, updated on the clk edge of the deciding tick):
  - IDLE/PLAY: leds = one-hot at pos.
  - WIN_L: win_left=1. leds = one-hot at bit 0 when blink phase=1, all zero when phase=0.
  - WIN_R: same as WIN_L, using win_right and bit NLED-1.
- Blink:
  - The flash counter counts ticks from 0 to FLASH_TICKS-1 while in a WIN state.
  - On wrap, the counter returns to 0 and the phase toggles.
  - On WIN entry: phase=1 and counter=0.
- Latency:
  - A button edge reaches sync output 2 clks later.
  - It is scored on the first tick after that, or on the second tick if it arrives within the same cycle as a tick.
  - leds change on that tick's clock edge.
- Between ticks: all state, pos and outputs are held constant.

Test Plan:
- Reset: drive rst=0 for 3 clks with buttons high, then release -> leds=9'b000010000 and win_*=0. No move while buttons stay held; state leaves IDLE only after both buttons read 0 at a tick.
- Single moves: from CENTER (pos 4), pulse btn_right high across 2 ticks then low -> pos 5, leds=9'b000100000. One left press -> back to 9'b000010000. Holding a button for 10 ticks counts once.
- Tie and glitch: both buttons pressed before the same tick -> leds unchanged. A 50-clk btn_left pulse placed wholly between two ticks -> no move.
- Right win: 4 separate right presses from center -> after the 4th tick leds=9'b100000000 and win_right=1. Further presses ignored. With FLASH_TICKS=2, leds alternate 9'b100000000 / 0 every 2 ticks.
- Left win then reset: 4 left presses -> win_left=1. Assert rst=0 for 1 clk during a blink-off phase -> next edge leds=9'b000010000, win_left=0, blink state cleared.
- Parameter sweep: NLED=3 -> a single press from center (pos 1) wins immediately. Verify pos never leaves the range 0..NLED-1 under random presses over 10k ticks.
